// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types and helpers for the streamed, tiled
//               D = A*B + C engine: the FSM state encoding, the
//               accumulator-width helper, element typedefs for the default
//               configuration and bit-offset helpers for the flattened
//               operand and result buses.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    // Default operand width; the element typedefs below describe the
    // default configuration and are handy for benches and neighbours.
    localparam int c_DEF_P = 8;

    // Accumulators are four times the operand width.
    function automatic int acc_w(input int p);
        return 4 * p;
    endfunction

    typedef logic [c_DEF_P-1:0]   elem_t;
    typedef logic [4*c_DEF_P-1:0] acc_t;

    // Explicitly sized state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // A slice element A[m][j] (m < M, j < KT), row-major over the slice.
    function automatic int a_off(input int m, input int j, input int kt, input int p);
        return (m * kt + j) * p;
    endfunction

    // B slice element B[j][n] (j < KT, n < N), row-major over the slice.
    function automatic int b_off(input int j, input int n, input int nn, input int p);
        return (j * nn + n) * p;
    endfunction

    // C/D element [m][n], row-major, each w bits wide.
    function automatic int d_off(input int m, input int n, input int nn, input int w);
        return (m * nn + n) * w;
    endfunction

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_acc_stream_dot.sv
`default_nettype none
// ============================================================================
// Module      : matmul_tile_dot
// Description : Combinational M x N array of KT-term dot products for one
//               reduction slice. Each output is the 4P-bit extended sum of
//               KT products of P-bit operands, sign- or zero-extended
//               according to i_signed.
// Ports       : i_a      - A slice, M*KT elements of P bits
//               i_b      - B slice, KT*N elements of P bits
//               i_signed - 1: operands signed, 0: unsigned
//               o_sum    - M*N partial sums of 4P bits
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_tile_dot
    import matmul_pkg::*;
#(
    parameter int M  = 8,
    parameter int N  = 4,
    parameter int KT = 4,
    parameter int P  = 8
) (
    input  logic [M*KT*P-1:0]        i_a,
    input  logic [KT*N*P-1:0]        i_b,
    input  logic                     i_signed,
    output logic [M*N*acc_w(P)-1:0]  o_sum
);

    localparam int c_ACC_W  = acc_w(P);
    localparam int c_PROD_W = 2 * P + 2;

    // Both operands are widened to 2P+2 bits (sign or zero fill), so the
    // truncated product is exact for either mode and can simply be
    // sign-extended into the accumulator width.
    function automatic logic [c_ACC_W-1:0] prod_ext(
        input logic [P-1:0] a,
        input logic [P-1:0] b,
        input logic         sgn
    );
        logic [c_PROD_W-1:0] ea;
        logic [c_PROD_W-1:0] eb;
        logic [c_PROD_W-1:0] pr;
        ea = {{(P+2){sgn & a[P-1]}}, a};
        eb = {{(P+2){sgn & b[P-1]}}, b};
        pr = ea * eb;
        return {{(c_ACC_W-c_PROD_W){pr[c_PROD_W-1]}}, pr};
    endfunction

    for (genvar gm = 0; gm < M; gm++) begin : g_row
        for (genvar gn = 0; gn < N; gn++) begin : g_col
            logic [c_ACC_W-1:0] w_sum;

            always_comb begin
                w_sum = '0;
                for (int j = 0; j < KT; j++) begin
                    w_sum = w_sum + prod_ext(i_a[a_off(gm, j, KT, P) +: P],
                                             i_b[b_off(j, gn, N, P) +: P],
                                             i_signed);
                end
            end

            assign o_sum[d_off(gm, gn, N, c_ACC_W) +: c_ACC_W] = w_sum;
        end
    end

endmodule : matmul_tile_dot
`default_nettype wire

// File: rtl/matmul_acc_stream.sv
`default_nettype none
// ============================================================================
// Module      : matmul_acc_stream
// Description : Sequential tiled D = A*B + C. C is loaded at job start,
//               K is streamed KT columns/rows per beat over a valid/ready
//               handshake, and D is presented with a valid/ready handshake
//               once all K/KT beats are accumulated. Accumulation wraps
//               modulo 2^(4P).
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               start_valid_i/ready_o  - job start handshake
//               signed_i, c_i          - job mode and C, sampled at start
//               ab_valid_i/ready_o     - operand beat handshake
//               a_i, b_i               - A and B slices for the beat
//               d_valid_o/d_ready_i    - result handshake
//               d_o                    - result D
//               busy_o                 - high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_acc_stream
    import matmul_pkg::*;
#(
    parameter int M  = 8,
    parameter int N  = 4,
    parameter int K  = 16,
    parameter int P  = 8,
    parameter int KT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_valid_i,
    output logic                     start_ready_o,
    input  logic                     signed_i,
    input  logic [M*N*acc_w(P)-1:0]  c_i,
    input  logic                     ab_valid_i,
    output logic                     ab_ready_o,
    input  logic [M*KT*P-1:0]        a_i,
    input  logic [KT*N*P-1:0]        b_i,
    output logic                     d_valid_o,
    input  logic                     d_ready_i,
    output logic [M*N*acc_w(P)-1:0]  d_o,
    output logic                     busy_o
);

    localparam int c_ACC_W = acc_w(P);
    localparam int c_BEATS = K / KT;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);

    if ((K % KT) != 0) begin : g_k_check
        $error("matmul_acc_stream: K must be a multiple of KT");
    end

    state_e                     r_state;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [M*N*c_ACC_W-1:0]     r_acc;
    logic                       r_mode;
    logic                       r_d_valid;
    logic                       r_busy;

    logic [M*N*c_ACC_W-1:0]     w_part;
    logic [M*N*c_ACC_W-1:0]     w_acc_next;

    matmul_tile_dot #(
        .M  (M),
        .N  (N),
        .KT (KT),
        .P  (P)
    ) u_dot (
        .i_a      (a_i),
        .i_b      (b_i),
        .i_signed (r_mode),
        .o_sum    (w_part)
    );

    for (genvar ge = 0; ge < M * N; ge++) begin : g_acc
        assign w_acc_next[ge*c_ACC_W +: c_ACC_W] =
            r_acc[ge*c_ACC_W +: c_ACC_W] + w_part[ge*c_ACC_W +: c_ACC_W];
    end

    // Ready signals are pure functions of state: no valid->ready path.
    assign start_ready_o = (r_state == ST_IDLE);
    assign ab_ready_o    = (r_state == ST_ACCUM);
    assign d_valid_o     = r_d_valid;
    assign busy_o        = r_busy;
    // The accumulator is only written in IDLE (on start) and ACCUM, so it
    // is stable for the whole DONE phase.
    assign d_o           = r_acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mode    <= 1'b0;
            r_d_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid_i) begin
                        r_acc   <= c_i;
                        r_mode  <= signed_i;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (ab_valid_i) begin
                        r_acc <= w_acc_next;
                        if (r_cnt == c_LAST) begin
                            r_cnt     <= '0;
                            r_d_valid <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (d_ready_i) begin
                        r_d_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_d_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : matmul_acc_stream
`default_nettype wire

// File: tb/tb_matmul_acc_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_acc_stream
// Description : Self-checking bench for matmul_acc_stream. Expected D
//               matrices come from a reference model over full A/B/C
//               matrices and are queued at stimulus time, then popped and
//               compared at the result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_acc_stream;

    localparam int M     = 8;
    localparam int N     = 4;
    localparam int K     = 16;
    localparam int P     = 8;
    localparam int KT    = 4;
    localparam int W     = 32;
    localparam int BEATS = K / KT;
    localparam int DW    = M * N * W;

    logic              clk;
    logic              rst_n;
    logic              start_valid;
    logic              start_ready;
    logic              sgn_in;
    logic [DW-1:0]     c_in;
    logic              ab_valid;
    logic              ab_ready;
    logic [M*KT*P-1:0] a_in;
    logic [KT*N*P-1:0] b_in;
    logic              d_valid;
    logic              d_ready;
    logic [DW-1:0]     d_out;
    logic              busy;

    logic [P-1:0] a_mat [M][K];
    logic [P-1:0] b_mat [K][N];
    logic [W-1:0] c_mat [M][N];

    logic [DW-1:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    matmul_acc_stream #(
        .M (M), .N (N), .K (K), .P (P), .KT (KT)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_valid_i (start_valid),
        .start_ready_o (start_ready),
        .signed_i      (sgn_in),
        .c_i           (c_in),
        .ab_valid_i    (ab_valid),
        .ab_ready_o    (ab_ready),
        .a_i           (a_in),
        .b_i           (b_in),
        .d_valid_o     (d_valid),
        .d_ready_i     (d_ready),
        .d_o           (d_out),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model(input bit sgn);
        logic [DW-1:0] v;
        logic [W-1:0]  acc;
        int            pa, pb;
        v = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                acc = c_mat[m][n];
                for (int k = 0; k < K; k++) begin
                    pa  = sgn ? int'($signed(a_mat[m][k])) : int'(a_mat[m][k]);
                    pb  = sgn ? int'($signed(b_mat[k][n])) : int'(b_mat[k][n]);
                    acc = acc + W'(pa * pb);
                end
                v[(m*N+n)*W +: W] = acc;
            end
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] pack_c();
        logic [DW-1:0] v;
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                v[(m*N+n)*W +: W] = c_mat[m][n];
        return v;
    endfunction

    function automatic logic [M*KT*P-1:0] pack_a(input int kb);
        logic [M*KT*P-1:0] v;
        for (int m = 0; m < M; m++)
            for (int j = 0; j < KT; j++)
                v[(m*KT+j)*P +: P] = a_mat[m][kb*KT+j];
        return v;
    endfunction

    function automatic logic [KT*N*P-1:0] pack_b(input int kb);
        logic [KT*N*P-1:0] v;
        for (int j = 0; j < KT; j++)
            for (int n = 0; n < N; n++)
                v[(j*N+n)*P +: P] = b_mat[kb*KT+j][n];
        return v;
    endfunction

    task automatic fill(input int mode, input logic [W-1:0] cval);
        for (int m = 0; m < M; m++) begin
            for (int k = 0; k < K; k++) begin
                case (mode)
                    0:       a_mat[m][k] = (m == k) ? 8'd1 : 8'd0;
                    1:       a_mat[m][k] = 8'hFF;
                    2:       a_mat[m][k] = (m == 0 && k == 0) ? 8'd1 : 8'd0;
                    3:       a_mat[m][k] = 8'd0;
                    default: a_mat[m][k] = P'($urandom);
                endcase
            end
            for (int n = 0; n < N; n++)
                c_mat[m][n] = (mode == 4) ? W'($urandom) : cval;
        end
        for (int k = 0; k < K; k++) begin
            for (int n = 0; n < N; n++) begin
                case (mode)
                    0:       b_mat[k][n] = P'(k + n);
                    1:       b_mat[k][n] = 8'h02;
                    2:       b_mat[k][n] = (k == 0 && n == 0) ? 8'd1 : 8'd0;
                    3:       b_mat[k][n] = 8'd0;
                    default: b_mat[k][n] = P'($urandom);
                endcase
            end
        end
    endtask

    // One full job. gap: percent chance of a stall before each beat;
    // hold: cycles d_ready is held low in DONE (0 keeps it high all job);
    // poke: drive start_valid with a different C/mode while busy.
    task automatic run_job(input bit sgn, input int gap, input int hold, input bit poke);
        logic [DW-1:0] cpk;
        logic [DW-1:0] snap;
        logic [DW-1:0] exp;
        cpk = pack_c();
        exp_q.push_back(model(sgn));
        check("start_ready_idle", start_ready, 1'b1);
        start_valid = 1'b1;
        sgn_in      = sgn;
        c_in        = cpk;
        d_ready     = (hold == 0);
        tick;
        start_valid = 1'b0;
        check("busy_accum", busy, 1'b1);
        for (int kb = 0; kb < BEATS; kb++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap; g++) begin
                ab_valid = 1'b0;
                a_in     = P'($urandom) == 0 ? '0 : '1;
                if (poke) begin
                    start_valid = 1'b1;
                    c_in        = ~cpk;
                    sgn_in      = ~sgn;
                end
                tick;
                check("dvalid_stall", d_valid, 1'b0);
            end
            ab_valid = 1'b1;
            a_in     = pack_a(kb);
            b_in     = pack_b(kb);
            if (poke) begin
                start_valid = 1'b1;
                c_in        = ~cpk;
                sgn_in      = ~sgn;
            end
            check("ab_ready_accum", ab_ready, 1'b1);
            check("start_ready_accum", start_ready, 1'b0);
            tick;
            check("dvalid_latency", d_valid, (kb == BEATS - 1) ? 1'b1 : 1'b0);
        end
        ab_valid    = 1'b0;
        start_valid = 1'b0;
        if (hold > 0) begin
            snap        = d_out;
            start_valid = 1'b1;
            c_in        = ~cpk;
            ab_valid    = 1'b1;
            a_in        = '1;
            b_in        = '1;
            for (int h = 0; h < hold; h++) begin
                tick;
                check("d_stable", (d_out == snap) ? 1'b1 : 1'b0, 1'b1);
                check("dvalid_hold", d_valid, 1'b1);
                check("start_ready_done", start_ready, 1'b0);
                check("ab_ready_done", ab_ready, 1'b0);
            end
            start_valid = 1'b0;
            ab_valid    = 1'b0;
            d_ready     = 1'b1;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("dvalid_handshake", d_valid, 1'b1);
            for (int e = 0; e < M * N; e++)
                check($sformatf("d[%0d][%0d]", e / N, e % N), d_out[e*W +: W], exp[e*W +: W]);
        end
        tick;
        d_ready = 1'b0;
        check("dvalid_drop", d_valid, 1'b0);
        check("busy_drop", busy, 1'b0);
        check("start_ready_back", start_ready, 1'b1);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        sgn_in      = 1'b0;
        c_in        = '0;
        ab_valid    = 1'b0;
        a_in        = '0;
        b_in        = '0;
        d_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_ab_ready", ab_ready, 1'b0);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_d_zero", (d_out == '0) ? 1'b1 : 1'b0, 1'b1);
        rst_n = 1'b1;
        tick;

        // Operand beats offered while idle must be refused.
        ab_valid = 1'b1;
        a_in     = '1;
        b_in     = '1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("idle_ab_ready", ab_ready, 1'b0);
            check("idle_busy", busy, 1'b0);
        end
        ab_valid = 1'b0;

        // Identity A against B[k][n] = k+n gives D[m][n] = m+n.
        fill(0, 32'd0);
        run_job(1'b1, 0, 0, 1'b0);
        check("identity_d32", d_out[(3*N+2)*W +: W], 32'd5);

        // All-FF times 2: -32 signed, 8160 unsigned.
        fill(1, 32'd0);
        run_job(1'b1, 0, 0, 1'b0);
        check("ff_signed", d_out[0 +: W], 32'hFFFF_FFE0);
        run_job(1'b0, 0, 0, 1'b0);
        check("ff_unsigned", d_out[(M*N-1)*W +: W], 32'd8160);

        // Wrap-around past the positive limit.
        fill(2, 32'h7FFF_FFFF);
        run_job(1'b1, 0, 0, 1'b0);
        check("wrap_d00", d_out[0 +: W], 32'h8000_0000);

        // Random data with stalls, backpressure and ignored starts.
        for (int r = 0; r < 3; r++) begin
            fill(4, 32'd0);
            run_job(r[0], 40, 5, 1'b1);
        end

        // Reset after two beats discards the job.
        fill(4, 32'd0);
        start_valid = 1'b1;
        sgn_in      = 1'b1;
        c_in        = pack_c();
        tick;
        start_valid = 1'b0;
        for (int kb = 0; kb < 2; kb++) begin
            ab_valid = 1'b1;
            a_in     = pack_a(kb);
            b_in     = pack_b(kb);
            tick;
        end
        ab_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_d_valid", d_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_start_ready", start_ready, 1'b1);
        check("mid_rst_ab_ready", ab_ready, 1'b0);
        check("mid_rst_d_zero", (d_out == '0) ? 1'b1 : 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("post_rst_d_valid", d_valid, 1'b0);

        fill(3, 32'd5);
        run_job(1'b1, 20, 2, 1'b0);
        check("post_rst_d00", d_out[0 +: W], 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_matmul_acc_stream
`default_nettype wire

// File: doc/matmul_acc_stream.md
Name: matmul_acc_stream

Overview:
- Sequential, tiled successor to the combinational matrix_multiplication_accumulation block.
- Computes D = A·B + C for M×K by K×N matrices with P-bit elements and 4P-bit accumulation.
- The K dimension is streamed KT columns/rows per beat over a valid/ready handshake, with a per-job signed/unsigned mode.
- Sits between operand-fetch streamers and the writeback path of the accelerator datapath.

Parameters:
- M, 8: rows of A, C and D.
- N, 4: columns of B, C and D.
- K, 16: reduction depth. Must be a multiple of KT; elaboration-time assertion.
- P, 8: operand element width in bits.
- KT, 4: reduction slice consumed per beat. BEATS = K/KT.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_valid_i  in  1  job start request.
- start_ready_o  out  1  job start accepted when high with start_valid_i.
- signed_i  in  1  operand mode for the job, sampled at start. 1 = signed, 0 = unsigned.
- c_i  in  M*N*4P  accumulator init C[m][n], sampled at start.
- ab_valid_i  in  1  operand beat valid.
- ab_ready_o  out  1  operand beat accepted.
- a_i  in  M*KT*P  A slice A[m][kb*KT+j].
- b_i  in  KT*N*P  B slice B[kb*KT+j][n].
- d_valid_o  out  1  result valid.
- d_ready_i  in  1  result consumer ready.
- d_o  out  M*N*4P  result D[m][n].
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ACCUM, DONE.
- Reset values: state = IDLE, beat counter = 0, accumulators = 0, d_o = 0, d_valid_o = 0, busy_o = 0. start_ready_o = 1 during reset, since it is combinationally high in IDLE.
- IDLE:
  - start_ready_o = 1, ab_ready_o = 0.
  - On start_valid_i: acc[m][n] <= c_i[m][n], mode <= signed_i, counter <= 0, go to ACCUM.
- ACCUM:
  - ab_ready_o = 1, start_ready_o = 0.
  - Each accepted beat: acc[m][n] += Σ_{j<KT} ext(A[m][j]) · ext(B[j][n]), counter++.
  - ext() sign-extends when mode = 1 and zero-extends when mode = 0.
  - Beats with ab_valid_i low are stalls; state is held.
  - On acceptance of beat BEATS-1: go to DONE.
- DONE:
  - d_valid_o = 1; d_o = acc, stable until handshake.
  - ab_ready_o = 0, start_ready_o = 0.
  - On d_ready_i: go to IDLE. d_valid_o drops the next cycle.
- Latency:
  - d_valid_o rises the cycle after the last beat is accepted.
  - The minimum job is 1 start cycle + BEATS beat cycles + 1 output cycle.
- Arithmetic:
  - Products are 2P bits; the sum of KT products is extended to 4P.
  - Accumulation wraps modulo 2^(4P), two's complement, with no saturation.
- Boundary conditions:
  - KT == K: single-beat job.
  - start_valid_i outside IDLE is ignored, and no state is latched.
  - ab_valid_i in IDLE or DONE is ignored.
  - d_ready_i outside DONE has no effect.
  - Back-to-back jobs: a start is accepted no earlier than the cycle after the D handshake.
  - Reset mid-job: immediate return to IDLE with all state cleared; the partial result is discarded and never presented.
- Combinational paths: handshake ready outputs depend only on state. There is no combinational valid→ready path.

Decomposition:
- Package matmul_pkg:
  - ACC_W = 4*P helper function.
  - State enum.
  - Packed element typedefs for operand and accumulator words.
  - Index helper functions for flattened buses.
- Sub-module matmul_tile_dot:
  - Combinational M×N array of KT-term dot products with a mode input.
  - Outputs 4P-bit partial sums; the accumulator registers and FSM stay in the top.

Test Plan:
- Identity with zero C: A = I(8×16 top-left), B[k][n] = k+n, C = 0, signed = 1 → D[m][n] = m+n; d_valid_o high exactly 1 cycle after beat 4.
- Signed/unsigned mode: all A = 8'hFF, all B = 8'h02, C = 0.
  - signed → every D = -32.
  - unsigned → every D = 8160.
- Wrap-around: C = 32'h7FFFFFFF, A[0][0] = B[0][0] = 1, other operands 0, signed → D[0][0] = 32'h80000000.
- Stalls and backpressure:
  - Random ab_valid_i gaps and d_ready_i held low 5 cycles; the file-driven vectors from the 8×4×16 data set must match.
  - d_o must be stable while stalled, and start_ready_o must stay 0 until the handshake.
- Reset mid-job: assert rst_ni low after beat 2 → all outputs at reset values. The next job, C = 5, A = B = 0, gives D = 5 everywhere.
- Ignored inputs: start_valid_i pulsed during ACCUM with a different C → result unaffected. ab_valid_i in IDLE → ab_ready_o = 0, with no accumulation.
